elixirchip_es1_spu_srl_arbiter: RTL and testbench
=================================================

Name: elixirchip_es1_spu_srl_arbiter

Overview:
- Round-robin arbiter that shares one elixirchip_es1_spu_op_srl instance among NUM_REQ requesters.
- Accepts one request per cke-enabled cycle and drives the shared unit's s_* inputs from registers.
- Tracks each in-flight operation with a tag pipeline matched to the unit's LATENCY, and returns every result to its originating requester, marked with an ID.
- Sits between SPU sequencer lanes and a single shift resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_BITS, $clog2(NUM_REQ), requester ID width
- LATENCY, 1, latency of the attached SRL unit in cke-enabled cycles (>=1)
- DATA_BITS, 8, data width
- MAX_SHIFT, DATA_BITS, maximum shift amount
- SHIFT_BITS, $clog2(MAX_SHIFT), shift amount width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cke  in  1  clock enable; all state advances only when cke=1
- s_valid  in  NUM_REQ  request valid, one bit per requester
- s_ready  out  NUM_REQ  request accepted (one-hot or zero)
- s_shift  in  NUM_REQ*SHIFT_BITS  packed shift amounts, requester i at [i*SHIFT_BITS +: SHIFT_BITS]
- s_data  in  NUM_REQ*DATA_BITS  packed data
- s_clear  in  NUM_REQ  per-request clear flag
- op_shift  out  SHIFT_BITS  to SRL unit s_shift
- op_data  out  DATA_BITS  to SRL unit s_data
- op_clear  out  1  to SRL unit s_clear
- op_valid  out  1  to SRL unit s_valid
- op_result  in  DATA_BITS  from SRL unit m_data
- m_valid  out  1  result valid
- m_id  out  ID_BITS  requester ID of the result
- m_data  out  DATA_BITS  result (equals op_result)
- busy  out  1  operations in flight

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - rr pointer to 0
  - op_* to 0
  - tag pipeline valid bits to 0, so m_valid=0 and m_id=0
  - in-flight counter to 0, so busy=0
- Reset mid-operation discards all in-flight results. No m_valid is produced for them after reset releases.
- Arbitration (combinational):
  - Search s_valid starting at the rr pointer, wrapping modulo NUM_REQ. The first set bit wins.
  - s_ready[win]=cke; all other s_ready bits are 0. No s_valid set gives s_ready=0.
- Transfer occurs when s_valid[i] & s_ready[i]. Requesters must hold their request stable until accepted.
- On a transfer cycle:
  - op_shift, op_data and op_clear are registered from the winner.
  - op_valid is set to 1.
  - The rr pointer becomes (win+1) mod NUM_REQ.
- On a cke=1 cycle with no transfer: op_valid=0 and the other op_* hold their values; the rr pointer holds.
- On a cke=0 cycle: all registers, including op_*, hold.
- Tag pipeline:
  - Depth LATENCY+1, entries {valid, id}, shifting only on cke=1.
  - Stage 0 is loaded together with the op_* registers.
  - Stage LATENCY aligns with op_result.
- m_valid and m_id come from the final tag stage; m_data is op_result, combinational.
  - Total latency from the accepting clk edge to m_valid is LATENCY+1 cke-enabled edges.
  - Outputs hold while cke=0. The consumer samples them on a clk edge with cke=1.
- The s_clear value is passed through unchanged in op_clear. Its effect on data comes from the unit (result = unit CLEAR_DATA). The arbiter reports that result like any other.
- In-flight counter (range 0..LATENCY+1), updated on cke=1:
  - +1 on transfer.
  - -1 when m_valid is presented.
  - Both in the same cycle leaves the count unchanged.
  - busy = (count != 0).
- Throughput is one op per cke cycle. The pipeline cannot overflow because there is no output backpressure.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0,… with no requester skipped.

Test Plan:
- Single request (NUM_REQ=4, LATENCY=1, cke=1): requester 2 sends data=0xB4, shift=3 → s_ready=4'b0100 for one cycle; 2 edges later m_valid=1, m_id=2, m_data=0x16; busy=1 while in flight, then 0.
- All four requesters held valid for 8 cycles → s_ready sequence 1,2,4,8,1,2,4,8; m_id sequence 0,1,2,3,0,1,2,3 lagging by 2 cycles; each m_data matches its own data>>shift.
- Wrap-around: rr pointer=3 with requesters 0 and 3 valid → 3 granted first, then 0; with only requester 1 valid and pointer=2 → 1 granted.
- cke stall: accept one op, then drive cke=0 for 5 cycles → op_*, tags and m_* hold; the result appears exactly 2 cke=1 edges after acceptance, never duplicated.
- Clear: requester 1 with s_clear=1 and unit CLEAR_DATA=0xFF → m_valid with m_id=1 and m_data=0xFF.
- Async reset: assert reset=0 between clock edges while 2 ops are in flight → m_valid, busy and op_valid drop to 0 immediately; after release, no stale m_valid appears and the rr pointer restarts at 0.

Source files
------------

// File: rtl/elixirchip_es1_spu_srl_arbiter.sv
// rtl/elixirchip_es1_spu_srl_arbiter.sv - round-robin arbiter sharing one SRL unit among NUM_REQ requesters
module elixirchip_es1_spu_srl_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_BITS    = $clog2(NUM_REQ),
    parameter int LATENCY    = 1,
    parameter int DATA_BITS  = 8,
    parameter int MAX_SHIFT  = DATA_BITS,
    parameter int SHIFT_BITS = $clog2(MAX_SHIFT)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cke,

    input  logic [NUM_REQ-1:0]              s_valid,
    output logic [NUM_REQ-1:0]              s_ready,
    input  logic [NUM_REQ*SHIFT_BITS-1:0]   s_shift,
    input  logic [NUM_REQ*DATA_BITS-1:0]    s_data,
    input  logic [NUM_REQ-1:0]              s_clear,

    output logic [SHIFT_BITS-1:0]           op_shift,
    output logic [DATA_BITS-1:0]            op_data,
    output logic                            op_clear,
    output logic                            op_valid,
    input  logic [DATA_BITS-1:0]            op_result,

    output logic                            m_valid,
    output logic [ID_BITS-1:0]              m_id,
    output logic [DATA_BITS-1:0]            m_data,
    output logic                            busy
);

    localparam int CNT_BITS = $clog2(LATENCY + 2) + 1;

    logic [ID_BITS-1:0]  rr;
    logic [ID_BITS-1:0]  win;
    logic [ID_BITS-1:0]  rr_next;
    logic                any;
    logic                transfer;

    logic                tag_valid [0:LATENCY];
    logic [ID_BITS-1:0]  tag_id    [0:LATENCY];

    logic [CNT_BITS-1:0] count;

    // First valid requester at or after the rr pointer, wrapping around.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && s_valid[(int'(rr) + k) % NUM_REQ]) begin
                any = 1'b1;
                win = ID_BITS'((int'(rr) + k) % NUM_REQ);
            end
        end
    end

    assign transfer = any & cke;
    assign s_ready  = transfer ? (NUM_REQ'(1) << win) : '0;
    assign rr_next  = (win == ID_BITS'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr       <= '0;
            op_shift <= '0;
            op_data  <= '0;
            op_clear <= 1'b0;
            op_valid <= 1'b0;
        end else if (cke) begin
            if (transfer) begin
                rr       <= rr_next;
                op_shift <= s_shift[win*SHIFT_BITS +: SHIFT_BITS];
                op_data  <= s_data[win*DATA_BITS +: DATA_BITS];
                op_clear <= s_clear[win];
                op_valid <= 1'b1;
            end else begin
                op_valid <= 1'b0;
            end
        end
    end

    // Stage 0 loads alongside op_*; stage LATENCY lines up with op_result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= LATENCY; k++) begin
                tag_valid[k] <= 1'b0;
                tag_id[k]    <= '0;
            end
        end else if (cke) begin
            tag_valid[0] <= transfer;
            tag_id[0]    <= transfer ? win : '0;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    assign m_valid = tag_valid[LATENCY];
    assign m_id    = tag_id[LATENCY];
    assign m_data  = op_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (cke) begin
            case ({transfer, m_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign busy = (count != '0);

endmodule

// File: tb/tb_elixirchip_es1_spu_srl_arbiter.sv
// tb/tb_elixirchip_es1_spu_srl_arbiter.sv - directed-vector bench for the SRL arbiter with a one-cycle SRL model
module tb_elixirchip_es1_spu_srl_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cke = 1'b1;
    logic [3:0]  s_valid = '0;
    logic [3:0]  s_ready;
    logic [11:0] s_shift = '0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_clear = '0;
    logic [2:0]  op_shift;
    logic [7:0]  op_data;
    logic        op_clear;
    logic        op_valid;
    logic [7:0]  op_result;
    logic        m_valid;
    logic [1:0]  m_id;
    logic [7:0]  m_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] fd [4] = '{8'h80, 8'hC3, 8'h5A, 8'hFF};
    logic [2:0] fs [4] = '{3'd1, 3'd2, 3'd4, 3'd7};
    logic [7:0] fr [4] = '{8'h40, 8'h30, 8'h05, 8'h01};

    elixirchip_es1_spu_srl_arbiter #(
        .NUM_REQ(4), .LATENCY(1), .DATA_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .s_valid(s_valid), .s_ready(s_ready), .s_shift(s_shift),
        .s_data(s_data), .s_clear(s_clear),
        .op_shift(op_shift), .op_data(op_data), .op_clear(op_clear),
        .op_valid(op_valid), .op_result(op_result),
        .m_valid(m_valid), .m_id(m_id), .m_data(m_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shift unit with LATENCY=1 and CLEAR_DATA=0xFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            op_result <= '0;
        else if (cke && op_valid)
            op_result <= op_clear ? 8'hFF : (op_data >> op_shift);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] sh, input logic c);
        s_data[i*8 +: 8]  = d;
        s_shift[i*3 +: 3] = sh;
        s_clear[i]        = c;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_m_id", 32'(m_id), 0);
        tick; tick;
        reset = 1'b1;
        tick;

        // Single request
        set_req(2, 8'hB4, 3'd3, 1'b0);
        s_valid = 4'b0100;
        #1 chk("single_ready", 32'(s_ready), 32'h4);
        tick;
        s_valid = 4'b0000;
        #1;
        chk("single_ready_off", 32'(s_ready), 0);
        chk("single_op_valid", 32'(op_valid), 1);
        chk("single_busy1", 32'(busy), 1);
        chk("single_mv_early", 32'(m_valid), 0);
        tick;
        chk("single_m_valid", 32'(m_valid), 1);
        chk("single_m_id", 32'(m_id), 2);
        chk("single_m_data", 32'(m_data), 32'h16);
        chk("single_busy2", 32'(busy), 1);
        chk("single_op_valid0", 32'(op_valid), 0);
        tick;
        chk("single_m_valid0", 32'(m_valid), 0);
        chk("single_busy0", 32'(busy), 0);

        // Wrap-around: pointer at 3, requesters 0 and 3
        set_req(0, 8'h22, 3'd0, 1'b0);
        set_req(3, 8'h88, 3'd3, 1'b0);
        s_valid = 4'b1001;
        #1 chk("wrap_ready3", 32'(s_ready), 32'h8);
        tick;
        s_valid = 4'b0001;
        #1 chk("wrap_ready0", 32'(s_ready), 32'h1);
        tick;
        s_valid = 4'b0000;
        #1;
        chk("wrap_mid3", 32'(m_id), 3);
        chk("wrap_md3", 32'(m_data), 32'h11);
        tick;
        chk("wrap_mid0", 32'(m_id), 0);
        chk("wrap_md0", 32'(m_data), 32'h22);
        tick;
        chk("wrap_idle", 32'(busy), 0);

        // Pointer at 2 with only requester 1 valid
        set_req(1, 8'h40, 3'd6, 1'b0);
        s_valid = 4'b0010;
        #1 chk("rr1_ready", 32'(s_ready), 32'h2);
        tick;
        #1 chk("rr2_ready1", 32'(s_ready), 32'h2);
        tick;
        s_valid = 4'b0000;
        #1;
        chk("rr2_m_id", 32'(m_id), 1);
        chk("rr2_m_data", 32'(m_data), 32'h01);
        tick; tick; tick;
        chk("rr2_idle", 32'(busy), 0);

        // Async reset with two ops in flight (pointer at 2 -> requester 0 first)
        set_req(0, 8'h55, 3'd1, 1'b0);
        s_valid = 4'b0011;
        #1 chk("ar_ready0", 32'(s_ready), 32'h1);
        tick;
        s_valid = 4'b0010;
        #1 chk("ar_ready1", 32'(s_ready), 32'h2);
        tick;
        s_valid = 4'b0000;
        #1;
        chk("ar_pre_busy", 32'(busy), 1);
        chk("ar_pre_mv", 32'(m_valid), 1);
        chk("ar_pre_opv", 32'(op_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_m_valid", 32'(m_valid), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_op_valid", 32'(op_valid), 0);
        #3 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("ar_no_stale", 32'(m_valid), 0);
        end

        // Fairness with all requesters held valid; pointer restarts at 0
        for (int i = 0; i < 4; i++) set_req(i, fd[i], fs[i], 1'b0);
        for (int c = 0; c < 10; c++) begin
            s_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            chk("fair_ready", 32'(s_ready), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
            if (c >= 2) begin
                chk("fair_m_valid", 32'(m_valid), 1);
                chk("fair_m_id", 32'(m_id), 32'((c - 2) % 4));
                chk("fair_m_data", 32'(m_data), 32'(fr[(c - 2) % 4]));
            end else begin
                chk("fair_m_valid0", 32'(m_valid), 0);
            end
            tick;
        end
        chk("fair_drained", 32'(m_valid), 0);

        // cke stall (pointer at 0)
        set_req(0, 8'h3C, 3'd2, 1'b0);
        s_valid = 4'b0001;
        #1 chk("stall_ready", 32'(s_ready), 32'h1);
        tick;
        s_valid = 4'b0000;
        cke = 1'b0;
        #1;
        chk("stall_op_valid", 32'(op_valid), 1);
        chk("stall_mv0", 32'(m_valid), 0);
        s_valid = 4'b0100;
        #1 chk("stall_no_ready", 32'(s_ready), 0);
        s_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("stall_hold_opv", 32'(op_valid), 1);
            chk("stall_hold_opd", 32'(op_data), 32'h3C);
            chk("stall_hold_ops", 32'(op_shift), 2);
            chk("stall_hold_mv", 32'(m_valid), 0);
            chk("stall_hold_busy", 32'(busy), 1);
        end
        cke = 1'b1;
        tick;
        chk("stall_m_valid", 32'(m_valid), 1);
        chk("stall_m_id", 32'(m_id), 0);
        chk("stall_m_data", 32'(m_data), 32'h0F);
        tick;
        chk("stall_no_dup", 32'(m_valid), 0);
        chk("stall_busy0", 32'(busy), 0);

        // Clear request from requester 1 (pointer at 1)
        set_req(1, 8'h12, 3'd1, 1'b1);
        s_valid = 4'b0010;
        #1 chk("clr_ready", 32'(s_ready), 32'h2);
        tick;
        s_valid = 4'b0000;
        s_clear = 4'b0000;
        #1 chk("clr_op_clear", 32'(op_clear), 1);
        tick;
        chk("clr_m_valid", 32'(m_valid), 1);
        chk("clr_m_id", 32'(m_id), 1);
        chk("clr_m_data", 32'(m_data), 32'hFF);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
